// File: rtl/truth_table_sweeper.sv
// Sweeps all 16 four-input vectors into a DUT and a golden circuit and captures the DUT truth table.
// Optional build macro SWEEP_STOP_ON_FAIL_EN ends the sweep at the first mismatching vector.
module truth_table_sweeper #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic        dut_out,
  input  logic        ref_out,
  output logic [3:0]  vec,
  output logic        busy,
  output logic        done,
  output logic [15:0] table_out,
  output logic [4:0]  mismatch_count,
  output logic [3:0]  first_fail,
  output logic        fail_valid
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETTLE = 2'd1;
  localparam logic [1:0] SAMPLE = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  // With no settle time every vector goes straight to its sampling cycle.
  localparam logic [1:0] ENTRY       = (SETTLE_CYCLES > 0) ? SETTLE : SAMPLE;
  localparam logic [3:0] SETTLE_LAST = 4'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

  logic [1:0] state;
  logic [3:0] settle_cnt;
  logic       miss;

  function automatic logic sweep_ends(input logic [3:0] v, input logic m);
`ifdef SWEEP_STOP_ON_FAIL_EN
    return (v == 4'd15) || m;
`else
    return (v == 4'd15) && (m || !m);
`endif
  endfunction

  assign miss = (dut_out != ref_out);
  assign busy = (state == SETTLE) || (state == SAMPLE);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      settle_cnt     <= 4'd0;
      vec            <= 4'd0;
      table_out      <= 16'h0000;
      mismatch_count <= 5'd0;
      first_fail     <= 4'd0;
      fail_valid     <= 1'b0;
    end else if (abort && (state != IDLE)) begin
      // Partial results stay visible after an abort.
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start && !abort) begin
            vec            <= 4'd0;
            settle_cnt     <= 4'd0;
            table_out      <= 16'h0000;
            mismatch_count <= 5'd0;
            first_fail     <= 4'd0;
            fail_valid     <= 1'b0;
            state          <= ENTRY;
          end
        end
        SETTLE: begin
          if (settle_cnt == SETTLE_LAST) begin
            state <= SAMPLE;
          end else begin
            settle_cnt <= settle_cnt + 4'd1;
          end
        end
        SAMPLE: begin
          table_out[vec] <= dut_out;
          if (miss) begin
            mismatch_count <= mismatch_count + 5'd1;
            if (!fail_valid) begin
              first_fail <= vec;
              fail_valid <= 1'b1;
            end
          end
          if (sweep_ends(vec, miss)) begin
            state <= DONE;
          end else begin
            vec        <= vec + 4'd1;
            settle_cnt <= 4'd0;
            state      <= ENTRY;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: one instance with the default settle time, one with zero settle time.
module tb_truth_table_sweeper;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic abort = 1'b0;
  logic start_a = 1'b0;
  logic start_b = 1'b0;
  int   mode = 0;
  logic sel = 1'b0;

  logic dut_a, ref_a, dut_b, ref_b;
  logic [3:0]  vec_a, vec_b, ff_a, ff_b;
  logic        busy_a, busy_b, done_a, done_b, fv_a, fv_b;
  logic [15:0] tbl_a, tbl_b;
  logic [4:0]  mc_a, mc_b;

  logic [3:0]  s_vec, s_ff;
  logic        s_busy, s_done, s_fv;
  logic [15:0] s_tbl;
  logic [4:0]  s_mc;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic        sel;
    int          mode;
    logic [15:0] tbl;
    int          mc;
    logic [3:0]  ff;
    logic        fv;
  } row_t;

  typedef struct {
    int          cyc;
    logic [15:0] tbl;
    logic [4:0]  mc;
    logic [3:0]  ff;
    logic        fv;
    logic [3:0]  vec;
  } exp_t;

  exp_t expq[$];
  row_t rows[7];

  always #5 clk = ~clk;

  function automatic logic f_ref(input logic [3:0] v);
    return (v[2] & v[1] & v[0]) | (~v[2] & ~v[0]);
  endfunction

  function automatic logic f_dut(input int m, input logic [3:0] v);
    case (m)
      1:       return 1'b0;
      2:       return f_ref(v) ^ (v == 4'd7);
      3:       return ~f_ref(v);
      4:       return 1'b1;
      default: return f_ref(v);
    endcase
  endfunction

  assign ref_a = f_ref(vec_a);
  assign dut_a = f_dut(mode, vec_a);
  assign ref_b = f_ref(vec_b);
  assign dut_b = f_dut(mode, vec_b);

  assign s_vec  = sel ? vec_b  : vec_a;
  assign s_ff   = sel ? ff_b   : ff_a;
  assign s_busy = sel ? busy_b : busy_a;
  assign s_done = sel ? done_b : done_a;
  assign s_fv   = sel ? fv_b   : fv_a;
  assign s_tbl  = sel ? tbl_b  : tbl_a;
  assign s_mc   = sel ? mc_b   : mc_a;

  truth_table_sweeper #(.SETTLE_CYCLES(2)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort),
    .dut_out(dut_a), .ref_out(ref_a), .vec(vec_a), .busy(busy_a), .done(done_a),
    .table_out(tbl_a), .mismatch_count(mc_a), .first_fail(ff_a), .fail_valid(fv_a)
  );

  truth_table_sweeper #(.SETTLE_CYCLES(0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort),
    .dut_out(dut_b), .ref_out(ref_b), .vec(vec_b), .busy(busy_b), .done(done_b),
    .table_out(tbl_b), .mismatch_count(mc_b), .first_fail(ff_b), .fail_valid(fv_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic exp_t expect_of(input row_t r);
    exp_t e;
    int s;
    logic [16:0] m;
    s = r.sel ? 0 : 2;
    e.cyc = 16 * (s + 1) + 1;
    e.tbl = r.tbl;
    e.mc  = 5'(r.mc);
    e.ff  = r.ff;
    e.fv  = r.fv;
    e.vec = 4'd15;
`ifdef SWEEP_STOP_ON_FAIL_EN
    if (r.fv) begin
      m     = (17'd1 << (int'(r.ff) + 1)) - 17'd1;
      e.mc  = 5'd1;
      e.tbl = r.tbl & m[15:0];
      e.cyc = int'(r.ff) * (s + 1) + s + 2;
      e.vec = r.ff;
    end
`else
    m = 17'd0;
`endif
    return e;
  endfunction

  task automatic pulse_start(input logic which);
    if (which) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic run_sweep(input row_t r, input int extra_at);
    exp_t e;
    int n;
    sel  = r.sel;
    mode = r.mode;
    expq.push_back(expect_of(r));
    pulse_start(r.sel);
    n = 1;
    chk("accept_clear_tbl", s_tbl, 16'h0000);
    chk("accept_busy", s_busy, 1'b1);
    while (!s_done && n < 200) begin
      if (n == extra_at) begin
        if (r.sel) start_b = 1'b1; else start_a = 1'b1;
      end
      @(posedge clk);
      #1;
      start_a = 1'b0;
      start_b = 1'b0;
      n++;
    end
    e = expq.pop_front();
    chk("done_cycle", n, e.cyc);
    chk("table_out", s_tbl, e.tbl);
    chk("mismatch_count", s_mc, e.mc);
    chk("first_fail", s_ff, e.ff);
    chk("fail_valid", s_fv, e.fv);
    chk("vec_at_done", s_vec, e.vec);
    chk("busy_at_done", s_busy, 1'b0);
    @(posedge clk);
    #1;
    chk("done_one_cycle", s_done, 1'b0);
    chk("hold_table", s_tbl, e.tbl);
  endtask

  initial begin
    int n;
    logic seen;
    rows[0] = '{1'b0, 0, 16'h8585, 0,  4'd0, 1'b0};
    rows[1] = '{1'b0, 1, 16'h0000, 6,  4'd0, 1'b1};
    rows[2] = '{1'b0, 2, 16'h8505, 1,  4'd7, 1'b1};
    rows[3] = '{1'b0, 3, 16'h7A7A, 16, 4'd0, 1'b1};
    rows[4] = '{1'b0, 4, 16'hFFFF, 10, 4'd1, 1'b1};
    rows[5] = '{1'b1, 0, 16'h8585, 0,  4'd0, 1'b0};
    rows[6] = '{1'b1, 2, 16'h8505, 1,  4'd7, 1'b1};

    #12;
    chk("rst_vec", vec_a, 4'd0);
    chk("rst_busy", busy_a, 1'b0);
    chk("rst_done", done_a, 1'b0);
    chk("rst_table", tbl_a, 16'h0000);
    chk("rst_mc", mc_a, 5'd0);
    chk("rst_ff_fv", {ff_a, fv_a}, 5'd0);
    chk("rst_b_all", {vec_b, busy_b, done_b, tbl_b, mc_b, ff_b, fv_b}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (rows[i]) run_sweep(rows[i], 0);

    // Extra start mid-sweep must not restart or shift the sweep.
    run_sweep(rows[0], 10);

    // Abort while vector 5 is being settled.
    sel = 1'b0;
    mode = 0;
    pulse_start(1'b0);
    n = 1;
    while (vec_a != 4'd5 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("abort_reach_vec5", vec_a, 4'd5);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    chk("abort_busy", busy_a, 1'b0);
    chk("abort_done", done_a, 1'b0);
    chk("abort_table", tbl_a, 16'h0005);
    seen = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk);
      #1;
      seen = seen | done_a | busy_a;
    end
    chk("abort_no_done", seen, 1'b0);
    run_sweep(rows[0], 0);

    // Abort together with start in IDLE: start ignored.
    abort = 1'b1;
    pulse_start(1'b0);
    abort = 1'b0;
    chk("abort_start_idle", busy_a, 1'b0);

    // Asynchronous reset mid-sweep.
    mode = 0;
    pulse_start(1'b0);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
    end
    chk("pre_reset_busy", busy_a, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_vec", vec_a, 4'd0);
    chk("midrst_busy", busy_a, 1'b0);
    chk("midrst_table", tbl_a, 16'h0000);
    chk("midrst_rest", {done_a, mc_a, ff_a, fv_a}, 11'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_sweep(rows[5], 0);

    if (expq.size() != 0) chk("queue_empty", expq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/truth_table_sweeper.md
# truth_table_sweeper

Sequential test controller for the four-input combinational lab circuits (minimisation, BCD-to-Gray, equivalence-check exercises). On command it drives all 16 input combinations A,B,C,D into a device-under-test circuit and a golden reference circuit, one vector at a time. After a programmable settle time it samples both outputs. It captures the DUT truth table and reports mismatch count and the first failing vector through a start/busy/done handshake.

## Interface
- SETTLE_CYCLES, default 2: idle cycles between driving a vector and sampling; legal range 0..15.
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin sweep; sampled only in IDLE.
- abort  in  1  synchronous abort; returns to IDLE without done.
- dut_out  in  1  output of circuit under test.
- ref_out  in  1  output of golden circuit.
- vec  out  4  applied input vector; A=vec[3], B=vec[2], C=vec[1], D=vec[0].
- busy  out  1  high in SETTLE and SAMPLE.
- done  out  1  one-cycle pulse at end of sweep.
- table_out  out  16  bit i = dut_out sampled with vec==i.
- mismatch_count  out  5  vectors where dut_out != ref_out, 0..16.
- first_fail  out  4  lowest failing vector; valid when fail_valid.
- fail_valid  out  1  at least one mismatch this sweep.

## Operation
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE: start=1 → vec=0, settle counter=0, table_out/mismatch_count/first_fail/fail_valid cleared. Go to SETTLE if SETTLE_CYCLES>0, else SAMPLE.
- SETTLE: hold vec; after SETTLE_CYCLES cycles in SETTLE → SAMPLE.
- SAMPLE, one cycle:
  - table_out[vec] <= dut_out.
  - If dut_out != ref_out: mismatch_count+1. If fail_valid=0, set first_fail=vec and fail_valid=1.
  - If vec==15 → DONE; else vec+1 and → SETTLE (or SAMPLE if SETTLE_CYCLES=0).
- DONE: done=1 for this cycle only, → IDLE.
- Results and vec hold their values in IDLE until the next accepted start.
- start outside IDLE is ignored. No queuing.
- abort=1 in SETTLE/SAMPLE/DONE → IDLE next edge. done is not asserted. Partial results are retained. abort has priority over the SAMPLE update in the same cycle. abort in IDLE has no effect. abort and start together in IDLE: abort wins, start is ignored.
- vec increments never wrap. Sweep ends at 15.
- mismatch_count saturates naturally at 16 (5 bits).
- X/Z on dut_out is compared as-is. No filtering is applied.

## Timing
- Reset (async, rst_n=0): state IDLE; vec=0, busy=0, done=0, table_out=16'h0000, mismatch_count=0, first_fail=0, fail_valid=0. Reset mid-sweep aborts immediately and clears results.
- Each vector occupies SETTLE_CYCLES+1 cycles.
- done is high exactly 16·(SETTLE_CYCLES+1)+1 cycles after the edge that accepted start. With the default, this is 49 cycles.
- busy rises on the edge after start is accepted. It falls on the edge entering DONE.
- vec changes on the edge entering SETTLE (or SAMPLE if SETTLE_CYCLES=0). It is stable through the sampling edge.
- Back-to-back: start asserted during the DONE cycle is ignored. The earliest accepted start is the first IDLE cycle after DONE.

## Configuration
- SWEEP_STOP_ON_FAIL_EN defined: the first mismatch in SAMPLE ends the sweep. The FSM goes to DONE instead of advancing, and done pulses next cycle. mismatch_count is then 1, table_out holds bits up to and including first_fail, and vec holds first_fail.
- Not defined: the full 16-vector sweep always runs.

## Test plan
- Circuit F=BCD+B'D' on both dut_out and ref_out, SETTLE_CYCLES=2, start pulse → done at cycle 49, table_out=16'h8585, mismatch_count=0, fail_valid=0.
- dut_out stuck at 0, ref_out=F → table_out=16'h0000, mismatch_count=6, first_fail=0, fail_valid=1. With SWEEP_STOP_ON_FAIL_EN: done 4 cycles after start, mismatch_count=1, vec=0.
- dut_out = F with vector 7 inverted → table_out=16'h8505, mismatch_count=1, first_fail=7.
- abort asserted while vec=5 → IDLE next cycle, no done pulse, busy=0, table_out bits 0..4 retained. A following start clears the results and sweeps fully.
- rst_n pulsed low mid-sweep → all outputs zero immediately. start during busy → ignored, done still at cycle 49 from the original start.
- SETTLE_CYCLES=0 → done at cycle 17, table_out=16'h8585.
